// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcodes, ALU codes, state/class enums and strobe bundle for control_unit
package cu_pkg;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3,
                         OP_SUB = 5'd4, OP_SHR = 5'd5, OP_SHRA = 5'd6, OP_SHL = 5'd7,
                         OP_ROR = 5'd8, OP_ROL = 5'd9, OP_AND = 5'd10, OP_OR = 5'd11,
                         OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14, OP_DIV = 5'd15,
                         OP_MUL = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19,
                         OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23,
                         OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;

  // ALU operation codes share the opcode numbering of the corresponding instruction
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T6W, ST_T7, ST_HALT
  } cu_state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
  } cu_class_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic pcout, pcin, incpc;
    logic marin, mdrin, mdrout, read, write;
    logic irin, yin, zin_low, zin_high, zlowout, zhighout;
    logic hiin, loin, hiout, loout, cout, in_portout, outportenable, conin;
  } cu_ctl_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - maps the 5-bit opcode to an instruction class
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [3:0] o_cls
);

  always_comb begin
    o_cls = CLS_NOP;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT:  o_cls = CLS_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:       o_cls = CLS_ALU_I;
      OP_LD:                          o_cls = CLS_LD;
      OP_LDI:                         o_cls = CLS_LDI;
      OP_ST:                          o_cls = CLS_ST;
      OP_MUL, OP_DIV:                 o_cls = CLS_MULDIV;
      OP_BR:                          o_cls = CLS_BR;
      OP_JR:                          o_cls = CLS_JR;
      OP_JAL:                         o_cls = CLS_JAL;
      OP_IN:                          o_cls = CLS_IN;
      OP_OUT:                         o_cls = CLS_OUT;
      OP_MFHI:                        o_cls = CLS_MFHI;
      OP_MFLO:                        o_cls = CLS_MFLO;
      OP_HALT:                        o_cls = CLS_HALT;
      default:                        o_cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore fetch/execute sequencer; CU_MEM_WAIT_EN adds a wait state after each Read cycle
module control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Con,
  input  logic        Stop,
  output logic [4:0]  operation,
  output logic        Gra, Grb, Grc,
  output logic        Rin, Rout, BAout,
  output logic        PCout, PCin, IncPC,
  output logic        MARin, MDRin, MDRout, Read, Write,
  output logic        IRin, Yin, Zin_low, Zin_high, Zlowout, Zhighout,
  output logic        HIin, LOin, HIout, LOout, Cout, In_Portout, outPortenable, ConIn,
  output logic        Run
);

  cu_state_t  r_state, w_next;
  cu_class_t  r_cls;
  logic [4:0] r_opc;
  logic       r_con, r_stop_pend;
  logic [3:0] w_cls;
  cu_ctl_t    w_ctl;
  logic [4:0] w_op;
  logic       w_last;
  logic       w_ir_unused;

  assign w_ir_unused = ^IR[26:0];

  cu_decode u_decode (.i_opcode(IR[31:27]), .o_cls(w_cls));

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state     <= ST_RESET;
      r_cls       <= CLS_NOP;
      r_opc       <= '0;
      r_con       <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_T2) begin
        r_cls <= cu_class_t'(w_cls);
        r_opc <= IR[31:27];
      end
      // CON flip-flop is loaded at T3 of br, so it is stable by T5
      if (r_state == ST_T5) r_con <= Con;
      if (Stop) r_stop_pend <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_ctl  = '0;
    w_op   = '0;
    w_last = 1'b0;
    case (r_state)
      ST_RESET: w_last = 1'b1;
      ST_T0: begin
        w_ctl.pcout = 1'b1; w_ctl.marin = 1'b1; w_ctl.incpc = 1'b1; w_ctl.zin_low = 1'b1;
        w_next = ST_T1;
      end
      ST_T1, ST_T1W: begin
        w_ctl.zlowout = 1'b1; w_ctl.pcin = 1'b1; w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1;
`ifdef CU_MEM_WAIT_EN
        w_next = (r_state == ST_T1) ? ST_T1W : ST_T2;
`else
        w_next = ST_T2;
`endif
      end
      ST_T2: begin
        w_ctl.mdrout = 1'b1; w_ctl.irin = 1'b1;
        w_next = ST_T3;
      end
      ST_T3: begin
        w_next = ST_T4;
        case (r_cls)
          CLS_ALU_R, CLS_ALU_I: begin w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.yin = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin w_ctl.grb = 1'b1; w_ctl.baout = 1'b1; w_ctl.yin = 1'b1; end
          CLS_MULDIV: begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.yin = 1'b1; end
          CLS_BR:     begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.conin = 1'b1; end
          CLS_JR:     begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pcin = 1'b1; w_last = 1'b1; end
          CLS_JAL:    begin w_ctl.pcout = 1'b1; w_ctl.grb = 1'b1; w_ctl.rin = 1'b1; end
          CLS_IN:     begin w_ctl.in_portout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; w_last = 1'b1; end
          CLS_OUT:    begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.outportenable = 1'b1; w_last = 1'b1; end
          CLS_MFHI:   begin w_ctl.hiout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; w_last = 1'b1; end
          CLS_MFLO:   begin w_ctl.loout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; w_last = 1'b1; end
          CLS_HALT:   w_next = ST_HALT;
          default:    w_last = 1'b1;
        endcase
      end
      ST_T4: begin
        w_next = ST_T5;
        case (r_cls)
          CLS_ALU_R:  begin w_ctl.grc = 1'b1; w_ctl.rout = 1'b1; w_ctl.zin_low = 1'b1; w_ctl.zin_high = 1'b1; w_op = r_opc; end
          CLS_ALU_I:  begin w_ctl.cout = 1'b1; w_ctl.zin_low = 1'b1; w_ctl.zin_high = 1'b1; w_op = r_opc; end
          CLS_LD, CLS_LDI, CLS_ST: begin w_ctl.cout = 1'b1; w_ctl.zin_low = 1'b1; w_op = ALU_ADD; end
          CLS_MULDIV: begin w_ctl.grb = 1'b1; w_ctl.rout = 1'b1; w_ctl.zin_low = 1'b1; w_ctl.zin_high = 1'b1; w_op = r_opc; end
          CLS_BR:     begin w_ctl.pcout = 1'b1; w_ctl.yin = 1'b1; end
          CLS_JAL:    begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.pcin = 1'b1; w_last = 1'b1; end
          default:    w_last = 1'b1;
        endcase
      end
      ST_T5: begin
        w_next = ST_T6;
        case (r_cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin w_ctl.zlowout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; w_last = 1'b1; end
          CLS_LD, CLS_ST: begin w_ctl.zlowout = 1'b1; w_ctl.marin = 1'b1; end
          CLS_MULDIV: begin w_ctl.zlowout = 1'b1; w_ctl.loin = 1'b1; end
          CLS_BR:     begin w_ctl.cout = 1'b1; w_ctl.zin_low = 1'b1; w_op = ALU_ADD; end
          default:    w_last = 1'b1;
        endcase
      end
      ST_T6, ST_T6W: begin
        w_next = ST_T7;
        case (r_cls)
          CLS_LD: begin
            w_ctl.read = 1'b1; w_ctl.mdrin = 1'b1;
`ifdef CU_MEM_WAIT_EN
            w_next = (r_state == ST_T6) ? ST_T6W : ST_T7;
`endif
          end
          CLS_ST:     begin w_ctl.gra = 1'b1; w_ctl.rout = 1'b1; w_ctl.mdrin = 1'b1; end
          CLS_MULDIV: begin w_ctl.zhighout = 1'b1; w_ctl.hiin = 1'b1; w_last = 1'b1; end
          CLS_BR:     begin w_ctl.zlowout = 1'b1; w_ctl.pcin = r_con; w_last = 1'b1; end
          default:    w_last = 1'b1;
        endcase
      end
      ST_T7: begin
        w_last = 1'b1;
        if (r_cls == CLS_LD) begin w_ctl.mdrout = 1'b1; w_ctl.gra = 1'b1; w_ctl.rin = 1'b1; end
        if (r_cls == CLS_ST) w_ctl.write = 1'b1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RESET;
    endcase
    // a pending Stop replaces the next fetch with HALT
    if (w_last) w_next = (r_stop_pend || Stop) ? ST_HALT : ST_T0;
  end

  assign operation     = w_op;
  assign Gra           = w_ctl.gra;
  assign Grb           = w_ctl.grb;
  assign Grc           = w_ctl.grc;
  assign Rin           = w_ctl.rin;
  assign Rout          = w_ctl.rout;
  assign BAout         = w_ctl.baout;
  assign PCout         = w_ctl.pcout;
  assign PCin          = w_ctl.pcin;
  assign IncPC         = w_ctl.incpc;
  assign MARin         = w_ctl.marin;
  assign MDRin         = w_ctl.mdrin;
  assign MDRout        = w_ctl.mdrout;
  assign Read          = w_ctl.read;
  assign Write         = w_ctl.write;
  assign IRin          = w_ctl.irin;
  assign Yin           = w_ctl.yin;
  assign Zin_low       = w_ctl.zin_low;
  assign Zin_high      = w_ctl.zin_high;
  assign Zlowout       = w_ctl.zlowout;
  assign Zhighout      = w_ctl.zhighout;
  assign HIin          = w_ctl.hiin;
  assign LOin          = w_ctl.loin;
  assign HIout         = w_ctl.hiout;
  assign LOout         = w_ctl.loout;
  assign Cout          = w_ctl.cout;
  assign In_Portout    = w_ctl.in_portout;
  assign outPortenable = w_ctl.outportenable;
  assign ConIn         = w_ctl.conin;
  assign Run           = (r_state != ST_RESET) && (r_state != ST_HALT);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IR, input, 32, the current instruction register contents; opcode is IR[31:27].
REQ-004 SHALL have port Con, input, 1, the branch-condition flag from the datapath CON flip-flop.
REQ-005 SHALL have port Stop, input, 1, a request to halt after the current instruction completes.
REQ-006 SHALL have port operation, output, 5, the ALU operation code presented to the datapath ALU.
REQ-007 SHALL have port Gra/Grb/Grc, output, 1 each, the register-field selects for select-and-encode.
REQ-008 SHALL have port Rin/Rout/BAout, output, 1 each, the general-register write, read and base-address-read strobes.
REQ-009 SHALL have port PCout/PCin/IncPC, output, 1 each, the PC bus-drive, PC load and increment strobes.
REQ-010 SHALL have port MARin/MDRin/MDRout/Read/Write, output, 1 each, the memory-path strobes.
REQ-011 SHALL have port IRin/Yin/Zin_low/Zin_high/Zlowout/Zhighout, output, 1 each, the IR, Y and Z strobes.
REQ-012 SHALL have port HIin/LOin/HIout/LOout/Cout/In_Portout/outPortenable/ConIn, output, 1 each, the remaining datapath strobes.
REQ-013 SHALL have port Run, output, 1, high while executing and low in RESET and HALT.

Function
REQ-014 SHALL be a Moore machine: every output is decoded only from the registered state and the latched opcode class.
REQ-015 SHALL step through states RESET -> T0 -> T1 -> T2 -> T3..T7 -> T0, advancing exactly one state per clock.
REQ-016 SHALL fetch as follows: T0 asserts PCout, MARin, IncPC, Zin_low; T1 asserts Zlowout, PCin, Read, MDRin; T2 asserts MDRout, IRin.
REQ-017 SHALL latch the opcode class from IR[31:27] on entry to T3, and hold it until the next T0.
REQ-018 SHALL execute ALU 3-register operations as: T3 Grb, Rout, Yin; T4 Grc, Rout, operation=opcode, Zin_low, Zin_high; T5 Zlowout, Gra, Rin; then T0.
REQ-019 SHALL execute immediate ALU operations as in REQ-018, except that T4 asserts Cout instead of Grc/Rout.
REQ-020 SHALL execute ld as: T3 Grb, BAout, Yin; T4 Cout, operation=ADD, Zin_low; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
REQ-021 SHALL execute ldi as ld T3-T4, followed by T5 Zlowout, Gra, Rin.
REQ-022 SHALL execute st as ld T3-T5, followed by T6 Gra, Rout, MDRin and T7 Write.
REQ-023 SHALL execute mul/div as: T3 Gra, Rout, Yin; T4 Grb, Rout, operation, Zin_low, Zin_high; T5 Zlowout, LOin; T6 Zhighout, HIin.
REQ-024 SHALL execute br as: T3 Gra, Rout, ConIn; T4 PCout, Yin; T5 Cout, ADD, Zin_low; T6 Zlowout, plus PCin only if Con=1.
REQ-025 SHALL execute the remaining single-step operations at T3 and then return to T0: jr (Gra, Rout, PCin), in (In_Portout, Gra, Rin), out (Gra, Rout, outPortenable), mfhi (HIout, Gra, Rin), mflo (LOout, Gra, Rin), nop (none).
REQ-026 SHALL execute jal as: T3 PCout, Grb-selected R15 Rin; T4 Gra, Rout, PCin.
REQ-027 SHALL treat any undefined opcode as nop.
REQ-028 SHALL enter HALT when the halt opcode is decoded at T3; HALT asserts no strobes and is exited only by reset.
REQ-029 SHALL, when Stop is sampled high in any state, complete the current instruction and enter HALT in place of the next T0.

Reset
REQ-030 SHALL, while clear=0, force the state to RESET asynchronously and drive every output, including operation and Run, to 0.
REQ-031 SHALL move from RESET to T0 on the first rising Clock edge after clear deasserts; a reset mid-instruction abandons that instruction.

Configuration
REQ-032 SHALL, with macro CU_MEM_WAIT_EN defined, insert a wait state after every Read cycle (T1, ld T6) that repeats that cycle's strobes, giving synchronous RAM two cycles.
REQ-033 SHALL, without CU_MEM_WAIT_EN, have no wait states, with the timing exactly as in REQ-016 to REQ-026.

Structure
REQ-034 SHALL take opcode localparams, ALU operation codes and the state enumeration from a shared package cu_pkg.
REQ-035 SHALL use one combinational sub-module, cu_decode, to map IR[31:27] to an opcode class.

Verification
REQ-036 SHALL cover: clear pulse low mid-T4 -> all outputs 0 immediately, then after release RESET, then T0 with PCout=MARin=IncPC=Zin_low=1.
REQ-037 SHALL cover: IR=add r1,r2,r3 -> Grb/Rout/Yin at T3, Grc/Rout/Zin at T4 with operation=ADD, Gra/Rin/Zlowout at T5, then T0.
REQ-038 SHALL cover: ld r2,0x45(r0) -> BAout at T3, Read/MDRin at T6, MDRout/Gra/Rin at T7; with CU_MEM_WAIT_EN, Read is asserted for 2 cycles.
REQ-039 SHALL cover: brzr with Con=0 -> no PCin at T6; with Con=1 -> PCin asserted at T6.
REQ-040 SHALL cover: Stop raised at T4 of mul -> HI/LO writes complete, then HALT with Run=0; the halt opcode -> HALT after T3.
